piso_tx: RTL
============

# piso_tx

Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out MSB-first on a single serial line, one bit per `clk` rising edge. It is the transmit end of the team's flip-flop-based serial path and pairs with a serial-in/parallel-out capture register on the receive side. `sframe` qualifies each serial bit so the receiver needs no separate bit counter.

## Interface
- `WIDTH`, default 8: data word width, legal range 2..32.
- `clk` input 1: rising-edge clock; all state updates on this edge.
- `rst` input 1: **synchronous, active-high reset**, sampled on `clk` rising edge.
- `load_valid` input 1: producer has a word on `load_data`.
- `load_data` input WIDTH: word to transmit; sampled only on an accept edge.
- `load_ready` output 1: block can accept a word this cycle.
- `sout` output 1: serial data bit, MSB first.
- `sframe` output 1: high while `sout` carries a valid bit.
- `done` output 1: one-cycle pulse coincident with the final serial bit of a word.

## Operation
- Two states: IDLE and SHIFT. State reg, WIDTH-bit shift reg, bit counter of width $clog2(WIDTH+2).
- Accept: `load_valid && load_ready` at a rising edge. Shift reg loads `load_data`, counter loads frame length (WIDTH, or WIDTH+1 with parity), state goes to SHIFT.
- IDLE: `load_ready`=1, `sframe`=0, `sout`=0, `done`=0.
- SHIFT: `sout`=shift reg MSB, `sframe`=1. Each edge shifts left by one, zero-fill, and decrements the counter.
- Last bit: counter==1. `done`=1 and `load_ready`=1 in this cycle.
  - Accept on that edge: reload and stay in SHIFT, giving gapless back-to-back frames.
  - No accept: return to IDLE.
- `load_ready`=0 in all other SHIFT cycles. `load_valid` there is ignored, not queued. The producer must hold `load_valid` and data until accepted.
- `rst`=1 wins over everything, including a simultaneous accept. It aborts any frame in progress and the partial word is discarded.

## Timing
- Reset values: state IDLE, shift reg 0, counter 0, `sout`=0, `sframe`=0, `done`=0, `load_ready`=1.
- Accept at edge N: first bit (data MSB) on `sout` during cycle N+1. Bit k (MSB=0) appears in cycle N+1+k.
- Frame length L = WIDTH, or WIDTH+1 with parity. `sframe` is high for cycles N+1..N+L. `done` is high in cycle N+L only.
- Back-to-back accept at edge N+L: next frame MSB appears in cycle N+L+1 and `sframe` stays continuously high.
- Throughput: one word per L cycles maximum. Latency from accept to first bit is 1 cycle.
- `rst` asserted at edge M: cycle M+1 shows `sframe`=0, `sout`=0, `load_ready`=1, with no `done` pulse.
- All outputs are registered or decoded from registered state only. There is no combinational path from `load_valid` to any output.

## Configuration
- Macro `PISO_TX_PARITY_EN`.
- Defined: an even-parity bit follows the data LSB. It equals XOR of the accepted word, is computed at accept time and held in a register. L = WIDTH+1, and `done` coincides with the parity bit.
- Undefined: no parity logic, L = WIDTH, and `done` coincides with the data LSB.
- Port list is identical in both builds.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `load_valid`=1 and `load_data`=0xFF.
  - Required: `sframe`=0, `sout`=0, `load_ready`=1, `done`=0 throughout, and no frame starts.
- Single word, WIDTH=8, no parity: accept 0xA5 at edge N.
  - Required: `sout` = 1,0,1,0,0,1,0,1 in cycles N+1..N+8.
  - Required: `sframe` high for exactly those 8 cycles, `done` high only at N+8, `load_ready`=0 during N+1..N+7.
- Back-to-back: 0xA5 accepted, then `load_valid` held with 0x3C.
  - Required: 0x3C accepted at edge N+8 and `sframe` high for 16 consecutive cycles.
  - Required: `sout` in N+9..N+16 = 0,0,1,1,1,1,0,0, and `done` at N+8 and N+16.
- Busy ignore: assert `load_valid` with 0x00 during cycles N+2..N+7 of a 0xA5 frame.
  - Required: frame bits unchanged, and 0x00 accepted only at edge N+8.
- Mid-frame reset: `rst`=1 at edge N+3 of a 0xA5 frame.
  - Required: cycle N+4 shows `sframe`=0, `sout`=0, `load_ready`=1, with no `done` pulse.
  - Required: a fresh 0x81 accept afterward produces the correct 1,0,0,0,0,0,0,1.
- Parity build (`PISO_TX_PARITY_EN`):
  - 0xA5 gives 9-bit frame ending in parity 0, with `done` at N+9.
  - 0x07 gives parity 1 in cycle N+9.

Source files
------------

// File: rtl/piso_tx_if.sv
// piso_tx_if: load handshake and serial output bundle for the PISO transmitter
// Signals:
//   load_valid / load_data / load_ready : word load handshake (producer -> transmitter)
//   sout / sframe / done                : serial bit, bit-valid qualifier, last-bit pulse
// Modports: master = producer/observer side, slave = transmitter side
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             sout;
    logic             sframe;
    logic             done;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  sout,
        input  sframe,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output sout,
        output sframe,
        output done
    );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter, MSB first, gapless back-to-back frames
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : piso_tx_if.slave (load_valid/load_data/load_ready in, sout/sframe/done out)
// Build option: define PISO_TX_PARITY_EN to append an even-parity bit after the data LSB
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    piso_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 2);
`ifdef PISO_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             w_shifting;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_sout;
    logic             w_sframe;
    logic             w_done;
`ifdef PISO_TX_PARITY_EN
    logic             r_par, w_par_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
`ifdef PISO_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef PISO_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    // Outputs depend only on registered state; load_valid only steers next state.
    always_comb begin
        w_shifting  = (r_state == S_SHIFT);
        w_last      = w_shifting && (r_cnt == CW'(1));
        w_ready     = !w_shifting || w_last;
        w_accept    = bus.load_valid && w_ready;
        w_sframe    = w_shifting;
        w_done      = w_last;
`ifdef PISO_TX_PARITY_EN
        // Data is fully shifted out by the final slot, which carries the stored parity.
        w_sout      = w_shifting && (w_last ? r_par : r_shift[WIDTH-1]);
        w_par_nxt   = w_accept ? ^bus.load_data : r_par;
`else
        w_sout      = w_shifting && r_shift[WIDTH-1];
`endif
        // An accept on the last bit reloads directly, keeping the line framed without a gap.
        w_state_nxt = w_accept ? S_SHIFT : (w_last ? S_IDLE : r_state);
        w_shift_nxt = w_accept ? bus.load_data : (w_shifting ? (r_shift << 1) : r_shift);
        w_cnt_nxt   = w_accept ? CW'(FRAME_LEN) : (w_shifting ? r_cnt - CW'(1) : r_cnt);
    end

    assign bus.load_ready = w_ready;
    assign bus.sout       = w_sout;
    assign bus.sframe     = w_sframe;
    assign bus.done       = w_done;
endmodule
